// File: rtl/aes_fifo_pkg.sv
// Shared constants and helpers for the AES word FIFO.
//   ptr_w()            : pointer width for a given depth ($clog2 wrapper, min 1)
//   AES_DATA_W/DEPTH   : defaults for the 32-bit bus-side word path
//   AES_BLK_DATA_W/..  : defaults for the 128-bit block variant
package aes_fifo_pkg;

  localparam int AES_DATA_W     = 32;
  localparam int AES_DEPTH      = 8;
  localparam int AES_BLK_DATA_W = 128;
  localparam int AES_BLK_DEPTH  = 4;

  // Width of a pointer that indexes 0..depth-1; never less than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array for aes_word_fifo.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset (read register only)
//   we, waddr, wdata : write port, written on the rising edge when we = 1
//   re, raddr        : read request and address
//   rdata            : registered read data; loads mem[raddr] when re = 1,
//                      otherwise holds. Reset to 0; array contents are not reset.
module fifo_ram
  import aes_fifo_pkg::*;
#(
  parameter int DATA_W = AES_DATA_W,
  parameter int DEPTH  = AES_DEPTH
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [ptr_w(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read-before-write: when waddr == raddr in the same cycle the old word
  // is returned, which is what a full FIFO doing read+write needs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/aes_word_fifo.sv
// Parametrised synchronous word FIFO between the AES256 bus-side input and
// the cipher datapath.
// Ports:
//   clk, resetn      : clock, asynchronous active-low reset
//   flush            : synchronous clear of pointers/count (highest priority)
//   write_fifo, data_in : write request and data
//   read_fifo        : read request
//   clear_err        : synchronous clear of overflow/underflow
//   data_out, data_valid : registered read data and one-cycle strobe
//   full, empty, almost_full, almost_empty, count : fill status (decoded
//                      combinationally from count)
//   overflow, underflow : sticky error flags
// Handshake: requests are not back-pressured by a ready; a write is taken
// when write_fifo & (!full | read_fifo) & !flush, a read when
// read_fifo & !empty & !flush, both judged on pre-edge state. Rejected
// requests raise the sticky error flags instead.
module aes_word_fifo
  import aes_fifo_pkg::*;
#(
  parameter int DATA_W   = AES_DATA_W,
  parameter int DEPTH    = AES_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     write_fifo,
  input  logic                     read_fifo,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     clear_err,
  output logic [DATA_W-1:0]        data_out,
  output logic                     data_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;
  logic          ov_set;
  logic          uf_set;

  // A write at full is only taken when a read frees the slot in the same
  // cycle; a read at empty is never taken, even alongside a write.
  assign wr_acc = write_fifo & (~full | read_fifo) & ~flush;
  assign rd_acc = read_fifo & ~empty & ~flush;
  assign ov_set = write_fifo & full & ~read_fifo & ~flush;
  assign uf_set = read_fifo & empty & ~flush;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (wr_acc && !rd_acc) begin
        count <= count + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - CW'(1);
      end
    end
  end

  // rd_acc already excludes flush, so flush drops the strobe here too.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_acc;
    end
  end

  // Sticky errors: a set in the same cycle as clear_err wins; flush keeps them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ov_set | (overflow  & ~clear_err);
      underflow <= uf_set | (underflow & ~clear_err);
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .we     (wr_acc),
    .waddr  (wr_ptr),
    .wdata  (data_in),
    .re     (rd_acc),
    .raddr  (rd_ptr),
    .rdata  (data_out)
  );

endmodule

// File: tb/tb_aes_word_fifo.sv
module tb_aes_word_fifo;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int AF = D - 1;
  localparam int AE = 1;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic         flush = 1'b0;
  logic         write_fifo = 1'b0;
  logic         read_fifo = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         clear_err = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [3:0]   count;
  logic         overflow;
  logic         underflow;

  aes_word_fifo #(
    .DATA_W   (W),
    .DEPTH    (D),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .write_fifo   (write_fifo),
    .read_fifo    (read_fifo),
    .data_in      (data_in),
    .clear_err    (clear_err),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // reference model state and scoreboard
  logic [W-1:0] m_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_dout = '0;
  logic         m_dv = 1'b0;
  logic         m_ov = 1'b0;
  logic         m_uf = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = m_q.size();
    check({tag, ".count"},  count, n);
    check({tag, ".full"},   full, n == D);
    check({tag, ".empty"},  empty, n == 0);
    check({tag, ".afull"},  almost_full, n >= AF);
    check({tag, ".aempty"}, almost_empty, n <= AE);
    check({tag, ".ovf"},    overflow, m_ov);
    check({tag, ".udf"},    underflow, m_uf);
    check({tag, ".valid"},  data_valid, m_dv);
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        check({tag, ".sb_nonempty"}, 1, 0);
      end else begin
        check({tag, ".dout"}, data_out, exp_q.pop_front());
      end
    end else begin
      check({tag, ".dout_hold"}, data_out, m_dout);
    end
  endtask

  // driver: one clock cycle with the given inputs, then model update and check
  task automatic step(input logic wr, input logic rd, input logic [W-1:0] din,
                      input logic fl, input logic ce, input string tag);
    int  n;
    bit  wa, ra, ovs, ufs;
    n = m_q.size();
    write_fifo = wr;
    read_fifo  = rd;
    data_in    = din;
    flush      = fl;
    clear_err  = ce;
    wa  = wr && ((n != D) || rd) && !fl;
    ra  = rd && (n != 0) && !fl;
    ovs = wr && (n == D) && !rd && !fl;
    ufs = rd && (n == 0) && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      m_q.delete();
    end else begin
      if (ra) begin
        m_dout = m_q.pop_front();
        exp_q.push_back(m_dout);
      end
      if (wa) m_q.push_back(din);
    end
    m_dv = ra;
    m_ov = ovs | (m_ov & !ce);
    m_uf = ufs | (m_uf & !ce);
    write_fifo = 1'b0;
    read_fifo  = 1'b0;
    flush      = 1'b0;
    clear_err  = 1'b0;
    check_all(tag);
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_dout = '0;
    m_dv = 1'b0;
    m_ov = 1'b0;
    m_uf = 1'b0;
  endtask

  initial begin
    // reset then idle
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("in_reset");
    #3;
    resetn = 1'b1;
    step(0, 0, '0, 0, 0, "idle");

    // three words then three reads
    step(1, 0, 32'hAAAAAAAA, 0, 0, "wrA");
    step(1, 0, 32'hBBBBBBBB, 0, 0, "wrB");
    step(1, 0, 32'hCCCCCCCC, 0, 0, "wrC");
    step(0, 1, '0, 0, 0, "rdA");
    check("rdA.word", data_out, 32'hAAAAAAAA);
    step(0, 1, '0, 0, 0, "rdB");
    check("rdB.word", data_out, 32'hBBBBBBBB);
    step(0, 1, '0, 0, 0, "rdC");
    check("rdC.word", data_out, 32'hCCCCCCCC);
    check("rdC.empty", empty, 1);
    step(0, 0, '0, 0, 0, "after_rd");

    // fill, overflow, read+write at full, drain across wrap
    for (int i = 1; i <= D; i++) step(1, 0, W'(i), 0, 0, "fill");
    check("fill.full", full, 1);
    step(1, 0, 32'hEEEEEEEE, 0, 0, "ovf_write");
    check("ovf.flag", overflow, 1);
    check("ovf.count", count, D);
    step(1, 1, 32'h9, 0, 0, "full_rw");
    check("full_rw.word", data_out, 32'h1);
    check("full_rw.count", count, D);
    for (int i = 0; i < D; i++) step(0, 1, '0, 0, 0, "drain");
    check("drain.last", data_out, 32'h9);
    step(0, 0, '0, 0, 1, "clr_ovf");

    // underflow, write with read at empty, clear
    step(0, 1, '0, 0, 0, "udf_read");
    check("udf.flag", underflow, 1);
    step(1, 1, 32'hDDDDDDDD, 0, 0, "udf_rw");
    check("udf_rw.count", count, 1);
    step(0, 0, '0, 0, 1, "clr_udf");
    check("clr_udf.flag", underflow, 0);
    step(0, 1, '0, 0, 0, "rdD");
    check("rdD.word", data_out, 32'hDDDDDDDD);

    // flush with concurrent write
    for (int i = 0; i < 5; i++) step(1, 0, 32'h5000 + W'(i), 0, 0, "pre_flush");
    step(1, 1, 32'h77777777, 1, 0, "flush");
    check("flush.count", count, 0);
    step(0, 1, '0, 0, 0, "post_flush_rd");

    // asynchronous reset mid-burst at count = 4
    for (int i = 0; i < 4; i++) step(1, 0, 32'h6000 + W'(i), 0, 0, "burst");
    step(0, 1, '0, 0, 0, "burst_rd");
    step(1, 0, 32'h6004, 0, 0, "burst_wr");
    check("burst.count", count, 4);
    resetn = 1'b0;
    #2;
    model_reset();
    check_all("async_rst");
    #3;
    resetn = 1'b1;
    step(0, 0, '0, 0, 0, "post_rst");

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 15) == 0), "rand");
    end
    for (int i = 0; i < D; i++) step(0, 1, '0, 0, 0, "final_drain");
    check("final.sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
